// File: rtl/riscv_32i_config_pkg.sv
// rtl/riscv_32i_config_pkg.sv - core-level sizing configuration
package riscv_32i_config_pkg;

    localparam int DATA_MEM_DEPTH = 256;

endpackage

// File: rtl/riscv_32i_defs_pkg.sv
// rtl/riscv_32i_defs_pkg.sv - shared RV32I word, byte-select and width definitions
package riscv_32i_defs_pkg;

    localparam int WORD_W    = 32;
    localparam int BYTE_W    = 8;
    localparam int NUM_LANES = WORD_W / BYTE_W;
    localparam int XADDR_W   = 32;

    typedef logic [WORD_W-1:0]    word_t;
    typedef logic [NUM_LANES-1:0] byte_sel_t;

endpackage

// File: rtl/data_men_interface.sv
// rtl/data_men_interface.sv - signal bundle for the data memory with driver and monitor views
interface data_men_interface
    import riscv_32i_defs_pkg::*;
#(
    parameter int ADDR_W = XADDR_W
) (
    input logic clk
);
    logic              rst_n;
    byte_sel_t         wr_sel;
    logic [ADDR_W-1:0] addr;
    word_t             wr_data;
    word_t             rd_data;

    clocking drv_cb @(posedge clk);
        output rst_n, wr_sel, addr, wr_data;
        input  rd_data;
    endclocking

    clocking mon_cb @(posedge clk);
        input rst_n, wr_sel, addr, wr_data, rd_data;
    endclocking

    modport mem (input clk, rst_n, wr_sel, addr, wr_data, output rd_data);
    modport drv (clocking drv_cb, input clk);
    modport mon (clocking mon_cb, input clk);

endinterface

// File: rtl/riscv_data_mem.sv
// rtl/riscv_data_mem.sv - word data memory: combinational read, byte-lane masked synchronous write
module riscv_data_mem
    import riscv_32i_defs_pkg::*;
    import riscv_32i_config_pkg::*;
#(
    parameter int DEPTH  = DATA_MEM_DEPTH,
    parameter int ADDR_W = XADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  byte_sel_t         wr_sel,
    input  logic [ADDR_W-1:0] addr,
    input  word_t             wr_data,
    output word_t             rd_data
);

    localparam int IDX_W = $clog2(DEPTH);

    word_t            mem_q [DEPTH];
    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic             unused_byte_offset;

    assign idx                = addr[IDX_W+1:2];
    assign unused_byte_offset = ^addr[1:0];

    // Upper address bits must be zero; there is no aliasing or wrap onto low words.
    generate
        if (ADDR_W > IDX_W + 2) begin : g_range_chk
            assign in_range = ~|addr[ADDR_W-1:IDX_W+2];
        end else begin : g_no_range_chk
            assign in_range = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem_q[w] <= '0;
            end
        end else if (in_range) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (wr_sel[l]) begin
                    mem_q[idx][l*BYTE_W +: BYTE_W] <= wr_data[l*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    assign rd_data = in_range ? mem_q[idx] : '0;

endmodule

// File: tb/tb_riscv_data_mem.sv
// tb/tb_riscv_data_mem.sv - directed vector and reference-model bench for riscv_data_mem
module tb_riscv_data_mem;
    import riscv_32i_defs_pkg::*;
    import riscv_32i_config_pkg::*;

    localparam int DEPTH  = DATA_MEM_DEPTH;
    localparam int ADDR_W = XADDR_W;
    localparam int NVEC   = 12;

    logic              clk;
    logic              rst_n;
    byte_sel_t         wr_sel;
    logic [ADDR_W-1:0] addr;
    word_t             wr_data;
    word_t             rd_data;

    int n_vec;
    int n_fail;

    typedef struct {
        string             name;
        byte_sel_t         sel;
        logic [ADDR_W-1:0] waddr;
        word_t             wdata;
        logic [ADDR_W-1:0] raddr;
        word_t             exp;
    } vec_t;

    vec_t  vecs [NVEC];
    word_t ref_mem [int];

    riscv_data_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_sel (wr_sel),
        .addr   (addr),
        .wr_data(wr_data),
        .rd_data(rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input word_t act, input word_t exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: rd_data=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic do_write(input byte_sel_t sel, input logic [ADDR_W-1:0] a, input word_t d);
        @(negedge clk);
        wr_sel  = sel;
        addr    = a;
        wr_data = d;
        @(posedge clk);
        #1;
        wr_sel  = '0;
    endtask

    task automatic do_read(input string name, input logic [ADDR_W-1:0] a, input word_t exp);
        wr_sel = '0;
        addr   = a;
        #1;
        chk(name, rd_data, exp);
    endtask

    function automatic word_t ref_read(input logic [ADDR_W-1:0] a);
        int unsigned wi;
        wi = int'(a >> 2);
        if (a >= ADDR_W'(4 * DEPTH)) return '0;
        if (ref_mem.exists(wi)) return ref_mem[wi];
        return '0;
    endfunction

    task automatic ref_write(input byte_sel_t sel, input logic [ADDR_W-1:0] a, input word_t d);
        int unsigned wi;
        word_t       w;
        wi = int'(a >> 2);
        if (a < ADDR_W'(4 * DEPTH)) begin
            w = ref_read(a);
            for (int l = 0; l < NUM_LANES; l++)
                if (sel[l]) w[l*8 +: 8] = d[l*8 +: 8];
            ref_mem[wi] = w;
        end
    endtask

    initial begin
        n_vec   = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        wr_sel  = '0;
        addr    = '0;
        wr_data = '0;

        vecs[0]  = '{"full_word",   4'hF,    32'h04, 32'h12345678, 32'h04, 32'h12345678};
        vecs[1]  = '{"no_sel_hold", 4'h0,    32'h04, 32'hAAAAAAAA, 32'h04, 32'h12345678};
        vecs[2]  = '{"lane_preload",4'hF,    32'h08, 32'hFFFFFFFF, 32'h08, 32'hFFFFFFFF};
        vecs[3]  = '{"lane1",       4'b0010, 32'h08, 32'h0000AB00, 32'h08, 32'hFFFFABFF};
        vecs[4]  = '{"lane3_2",     4'b1100, 32'h08, 32'h55660000, 32'h08, 32'h5566ABFF};
        vecs[5]  = '{"align_0d",    4'hF,    32'h0C, 32'hCAFEF00D, 32'h0D, 32'hCAFEF00D};
        vecs[6]  = '{"align_0e",    4'h0,    32'h0C, 32'h0,        32'h0E, 32'hCAFEF00D};
        vecs[7]  = '{"align_0f",    4'h0,    32'h0C, 32'h0,        32'h0F, 32'hCAFEF00D};
        vecs[8]  = '{"word0_init",  4'hF,    32'h00, 32'h11111111, 32'h00, 32'h11111111};
        vecs[9]  = '{"last_word",   4'hF,    ADDR_W'(4*(DEPTH-1)), 32'hA5A55A5A, ADDR_W'(4*(DEPTH-1)), 32'hA5A55A5A};
        vecs[10] = '{"oor_write",   4'hF,    ADDR_W'(4*DEPTH), 32'hBBBBBBBB, ADDR_W'(4*DEPTH), 32'h0};
        vecs[11] = '{"no_wrap_w0",  4'b1010, 32'h13, 32'h2222_3333, 32'h00, 32'h11111111};

        #1;
        do_read("reset_rd_10", 32'h10, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            do_write(vecs[i].sel, vecs[i].waddr, vecs[i].wdata);
            do_read(vecs[i].name, vecs[i].raddr, vecs[i].exp);
        end

        // Word 0x13 sits in word 4, untouched until now except by vecs[11].
        do_read("noncontig_1010", 32'h10, 32'h22000000 | 32'h00003300);

        // Old data is visible up to the edge, new data right after it.
        @(negedge clk);
        wr_sel  = 4'hF;
        addr    = 32'h04;
        wr_data = 32'h87654321;
        #1;
        chk("rdw_before_edge", rd_data, 32'h12345678);
        @(posedge clk);
        #1;
        chk("rdw_after_edge", rd_data, 32'h87654321);
        wr_sel = '0;

        do_write(4'hF, 32'h10, 32'hDEADBEEF);
        do_read("pre_reset_10", 32'h10, 32'hDEADBEEF);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_10", rd_data, 32'h0);
        do_write(4'hF, 32'h10, 32'h99999999);
        do_read("write_in_reset", 32'h10, 32'h0);
        do_read("reset_clr_08", 32'h08, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        do_read("after_release", 32'h10, 32'h0);

        for (int k = 0; k < 1000; k++) begin
            byte_sel_t         s;
            logic [ADDR_W-1:0] wa;
            logic [ADDR_W-1:0] ra;
            word_t             d;
            s  = byte_sel_t'($urandom_range(0, 15));
            d  = $urandom();
            wa = ADDR_W'($urandom_range(0, 4*DEPTH + 31));
            ra = ($urandom_range(0, 3) == 0) ? wa : ADDR_W'($urandom_range(0, 4*DEPTH + 31));
            if ($urandom_range(0, 31) == 0) wa = $urandom() | 32'h8000_0000;
            do_write(s, wa, d);
            ref_write(s, wa, d);
            do_read("random", ra, ref_read(ra));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
